// File: rtl/forex_pkg.sv
// rtl/forex_pkg.sv - shared types and register constants for the FOREX cycle reader
package forex_pkg;

    // Vertex IDs are PRED_WIDTH+1 bits wide across the accelerator
    localparam int PRED_WIDTH       = 7;
    localparam int VERTEX_W_DEFAULT = PRED_WIDTH + 1;

    // Ingest FSM: ACCEPT stores beats, DROP discards until the end of an overflowed cycle
    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } ingest_state_e;

    // Register addresses
    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_DATA   = 3'd1;
    localparam logic [2:0] ADDR_ACK    = 3'd2;

    // STATUS fields
    localparam int STATUS_COUNT_W    = 5;
    localparam int STATUS_PEND_LSB   = 8;
    localparam int STATUS_OVF_BIT    = 16;
    localparam int STATUS_EMPTY_BIT  = 17;

    // DATA fields
    localparam int          DATA_LAST_BIT  = 31;
    localparam logic [31:0] DATA_UNDERFLOW = 32'h4000_0000;

endpackage

// File: rtl/cycle_fifo_ram.sv
// rtl/cycle_fifo_ram.sv - FIFO storage, one write port, one asynchronous read port
//
// Ports:
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data {last, vertex}
//   raddr_i  - read address (asynchronous read)
//   rdata_o  - read data
// Contents are deliberately not reset.
module cycle_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/forex_cycle_reader.sv
// rtl/forex_cycle_reader.sv - Avalon-MM read slave that buffers complete arbitrage cycles
//
// Ports:
//   clk, reset_n           - clock, asynchronous active-low reset
//   chipselect, read       - Avalon read access
//   address[2:0]           - 0 STATUS, 1 DATA (pop), 2 ACK (read-to-clear overflow)
//   readdata[31:0]         - registered read data, held between reads
//   irq                    - level interrupt: cycles pending or overflow
//   cyc_valid/vertex/last  - vertex stream from the container core
//   cyc_ready              - high outside reset; overflow drops data instead of stalling
module forex_cycle_reader
    import forex_pkg::*;
#(
    parameter int VERTEX_W = VERTEX_W_DEFAULT,
    parameter int DEPTH    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                chipselect,
    input  logic                read,
    input  logic [2:0]          address,
    output logic [31:0]         readdata,
    output logic                irq,
    input  logic                cyc_valid,
    input  logic [VERTEX_W-1:0] cyc_vertex,
    input  logic                cyc_last,
    output logic                cyc_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = VERTEX_W + 1;

    // wr_spec runs ahead over the cycle in progress; wr_commit marks the end of
    // the last complete cycle, which is all the host is allowed to see.
    logic [PW-1:0]  wr_spec_q,   wr_spec_d;
    logic [PW-1:0]  wr_commit_q, wr_commit_d;
    logic [PW-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [7:0]     pend_q,      pend_d;
    logic           ovf_q,       ovf_d;
    ingest_state_e  state_q,     state_d;
    logic [31:0]    rdata_q,     rdata_d;
    logic           irq_q;

    logic [PW-1:0]  vis_count;
    logic [PW-1:0]  occupancy;
    logic           full;
    logic           rd_strobe;
    logic           ram_we;
    logic [EW-1:0]  ram_rdata;
    logic           head_last;
    logic           pend_inc;
    logic           pend_dec;
    logic           ovf_set;
    logic           ovf_clr;
    logic [31:0]    status_word;
    logic [31:0]    data_word;

    assign vis_count = wr_commit_q - rd_ptr_q;
    assign occupancy = wr_spec_q - rd_ptr_q;
    assign full      = (occupancy == PW'(DEPTH));
    assign rd_strobe = chipselect & read;
    assign head_last = ram_rdata[EW-1];

    cycle_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_spec_q[AW-1:0]),
        .wdata_i ({cyc_last, cyc_vertex}),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        status_word = '0;
        status_word[STATUS_COUNT_W-1:0] = STATUS_COUNT_W'(vis_count);
        status_word[STATUS_PEND_LSB +: 8] = pend_q;
        status_word[STATUS_OVF_BIT] = ovf_q;
        status_word[STATUS_EMPTY_BIT] = (vis_count == '0);

        data_word = '0;
        data_word[VERTEX_W-1:0] = ram_rdata[VERTEX_W-1:0];
        data_word[DATA_LAST_BIT] = head_last;
    end

    always_comb begin
        wr_spec_d   = wr_spec_q;
        wr_commit_d = wr_commit_q;
        rd_ptr_d    = rd_ptr_q;
        state_d     = state_q;
        rdata_d     = rdata_q;
        ram_we      = 1'b0;
        pend_inc    = 1'b0;
        pend_dec    = 1'b0;
        ovf_set     = 1'b0;
        ovf_clr     = 1'b0;

        // Ingest: full is judged on the pre-edge read pointer, so a pop in
        // the same cycle does not make room for this beat.
        if (cyc_valid) begin
            case (state_q)
                ST_ACCEPT: begin
                    if (!full) begin
                        ram_we    = 1'b1;
                        wr_spec_d = wr_spec_q + 1'b1;
                        if (cyc_last) begin
                            wr_commit_d = wr_spec_q + 1'b1;
                            pend_inc    = 1'b1;
                        end
                    end else begin
                        // Roll back the partial cycle; keep dropping until its end
                        wr_spec_d = wr_commit_q;
                        ovf_set   = 1'b1;
                        if (!cyc_last) begin
                            state_d = ST_DROP;
                        end
                    end
                end
                ST_DROP: begin
                    if (cyc_last) begin
                        state_d = ST_ACCEPT;
                    end
                end
                default: state_d = ST_ACCEPT;
            endcase
        end

        // Register reads use the pre-edge visible count
        if (rd_strobe) begin
            case (address)
                ADDR_STATUS: rdata_d = status_word;
                ADDR_DATA: begin
                    if (vis_count != '0) begin
                        rdata_d  = data_word;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        pend_dec = head_last;
                    end else begin
                        rdata_d = DATA_UNDERFLOW;
                    end
                end
                ADDR_ACK: begin
                    rdata_d = {31'b0, ovf_q};
                    ovf_clr = 1'b1;
                end
                default: rdata_d = '0;
            endcase
        end

        // A new overflow in the same cycle as an ACK must not be lost
        ovf_d = ovf_set | (ovf_q & ~ovf_clr);

        case ({pend_inc, pend_dec})
            2'b10:   pend_d = (pend_q == 8'hFF) ? pend_q : pend_q + 8'd1;
            2'b01:   pend_d = pend_q - 8'd1;
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_spec_q   <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            pend_q      <= '0;
            ovf_q       <= 1'b0;
            state_q     <= ST_ACCEPT;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            wr_spec_q   <= wr_spec_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            irq_q       <= (pend_q != 8'd0) | ovf_q;
        end
    end

    assign readdata  = rdata_q;
    assign irq       = irq_q;
    assign cyc_ready = reset_n;

endmodule

// File: tb/tb_forex_cycle_reader.sv
// tb/tb_forex_cycle_reader.sv - randomized and directed bench for forex_cycle_reader
module tb_forex_cycle_reader;

    localparam int VW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          chipselect;
    logic          read;
    logic [2:0]    address;
    logic [31:0]   readdata;
    logic          irq;
    logic          cyc_valid;
    logic [VW-1:0] cyc_vertex;
    logic          cyc_last;
    logic          cyc_ready;

    forex_cycle_reader #(.VERTEX_W(VW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .read       (read),
        .address    (address),
        .readdata   (readdata),
        .irq        (irq),
        .cyc_valid  (cyc_valid),
        .cyc_vertex (cyc_vertex),
        .cyc_last   (cyc_last),
        .cyc_ready  (cyc_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: committed entries, the cycle in progress, and flags
    logic [8:0]  m_vis[$];
    logic [8:0]  m_part[$];
    int          m_pend;
    bit          m_ovf;
    bit          m_drop;
    logic [31:0] exp_rdata;
    bit          exp_irq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_vis.delete();
        m_part.delete();
        m_pend    = 0;
        m_ovf     = 0;
        m_drop    = 0;
        exp_rdata = '0;
        exp_irq   = 0;
    endtask

    task automatic model_read(input logic [2:0] a);
        logic [8:0]  e;
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0: begin
                r[4:0]   = 5'(m_vis.size());
                r[15:8]  = 8'(m_pend);
                r[16]    = m_ovf;
                r[17]    = (m_vis.size() == 0);
            end
            3'd1: begin
                if (m_vis.size() > 0) begin
                    e = m_vis.pop_front();
                    r = {e[8], 23'b0, e[7:0]};
                    if (e[8]) m_pend--;
                end else begin
                    r = 32'h4000_0000;
                end
            end
            3'd2: begin
                r[0]  = m_ovf;
                m_ovf = 0;
            end
            default: r = '0;
        endcase
        exp_rdata = r;
    endtask

    task automatic model_beat(input logic [VW-1:0] vx, input bit l, input bit full_pre);
        if (m_drop) begin
            if (l) m_drop = 0;
        end else if (full_pre) begin
            m_part.delete();
            m_ovf  = 1;
            m_drop = !l;
        end else begin
            m_part.push_back({l, vx});
            if (l) begin
                foreach (m_part[i]) m_vis.push_back(m_part[i]);
                m_part.delete();
                if (m_pend < 255) m_pend++;
            end
        end
    endtask

    // One clock cycle of stimulus, model update and output checks
    task automatic tick(input bit v, input logic [VW-1:0] vx, input bit l,
                        input bit rd, input logic [2:0] a);
        bit full_pre;
        cyc_valid  = v;
        cyc_vertex = vx;
        cyc_last   = l;
        chipselect = rd;
        read       = rd;
        address    = a;
        exp_irq  = (m_pend != 0) || m_ovf;
        full_pre = (m_vis.size() + m_part.size()) == DEPTH;
        if (rd) model_read(a);
        if (v) model_beat(vx, l, full_pre);
        @(posedge clk);
        #1;
        check("irq", 32'(irq), 32'(exp_irq));
        check("cyc_ready", 32'(cyc_ready), 32'd1);
        check(rd ? "readdata" : "readdata_hold", readdata, exp_rdata);
        cyc_valid  = 0;
        cyc_last   = 0;
        chipselect = 0;
        read       = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, '0, 0, 0, 3'd0);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        tick(0, '0, 0, 1, a);
    endtask

    task automatic send_cycle(input int len, input int base);
        for (int i = 0; i < len; i++) tick(1, VW'(base + i), (i == len - 1), 0, 3'd0);
    endtask

    initial begin
        reset_n    = 0;
        chipselect = 0;
        read       = 0;
        address    = '0;
        cyc_valid  = 0;
        cyc_vertex = '0;
        cyc_last   = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(cyc_ready), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_readdata", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
        rd_reg(3'd0);
        check("reset_status", readdata, 32'h0002_0000);

        // Cycle {3,7,2}
        tick(1, 8'd3, 0, 0, 3'd0);
        tick(1, 8'd7, 0, 0, 3'd0);
        tick(1, 8'd2, 1, 0, 3'd0);
        idle(1);
        rd_reg(3'd0);
        check("c1_status", readdata, 32'h0000_0103);
        check("c1_irq", 32'(irq), 32'd1);
        rd_reg(3'd1);
        check("c1_d0", readdata, 32'd3);
        rd_reg(3'd1);
        check("c1_d1", readdata, 32'd7);
        rd_reg(3'd1);
        check("c1_d2", readdata, 32'h8000_0002);
        idle(1);
        check("c1_irq_fall", 32'(irq), 32'd0);

        // Single 20-beat cycle overflows entirely
        send_cycle(20, 40);
        idle(1);
        rd_reg(3'd0);
        check("ovf_status", readdata, 32'h0003_0000);
        rd_reg(3'd2);
        check("ovf_ack", readdata, 32'd1);
        idle(2);
        check("ovf_irq_clear", 32'(irq), 32'd0);

        // 14-beat cycle survives, 4-beat cycle dropped, 2-beat cycle fits
        send_cycle(14, 100);
        send_cycle(4, 150);
        send_cycle(2, 200);
        idle(1);
        rd_reg(3'd0);
        check("fill_status", readdata, 32'h0001_0210);
        rd_reg(3'd2);
        for (int i = 0; i < 16; i++) rd_reg(3'd1);
        rd_reg(3'd1);
        check("underflow", readdata, 32'h4000_0000);
        rd_reg(3'd0);
        check("drained_status", readdata, 32'h0002_0000);

        // Pop of the head concurrent with a commit
        send_cycle(2, 10);
        tick(1, 8'd20, 0, 0, 3'd0);
        tick(1, 8'd21, 0, 0, 3'd0);
        tick(1, 8'd22, 1, 1, 3'd1);
        check("conc_pop", readdata, 32'd10);
        rd_reg(3'd0);
        check("conc_status", readdata, 32'h0000_0204);
        for (int i = 0; i < 4; i++) rd_reg(3'd1);

        // Reset while in DROP mid-cycle
        for (int i = 0; i < 17; i++) tick(1, VW'(i), 0, 0, 3'd0);
        #2;
        reset_n = 0;
        #1;
        check("rst_drop_ready", 32'(cyc_ready), 32'd0);
        check("rst_drop_irq", 32'(irq), 32'd0);
        check("rst_drop_readdata", readdata, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
        rd_reg(3'd0);
        check("rst_drop_status", readdata, 32'h0002_0000);
        send_cycle(2, 60);
        rd_reg(3'd0);
        check("rst_after_status", readdata, 32'h0000_0102);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit          v;
            bit          l;
            bit          rd;
            int          r;
            logic [2:0]  a;
            v  = ($urandom_range(0, 99) < 35);
            l  = ($urandom_range(0, 4) == 0);
            rd = ($urandom_range(0, 2) == 0);
            r  = $urandom_range(0, 9);
            if (r < 5)       a = 3'd1;
            else if (r < 7)  a = 3'd0;
            else if (r < 8)  a = 3'd2;
            else             a = 3'($urandom_range(3, 7));
            tick(v, VW'($urandom_range(0, 255)), l, rd, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
